uart_tx_arbiter: RTL

//  Shares one uart_tx serializer between NUM_REQ byte sources.
//  - Selects requesters round-robin and captures the granted byte.
//  - Drives the serializer's i_Tx_DV/i_Tx_Byte and tracks its Active/Done outputs.
//  - Frame lock: a multi-byte message from one source is never interleaved with other sources.

---
 rtl/uart_tx_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer between NUM_REQ byte sources,
// with per-source frame lock so multi-byte messages are never interleaved.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic [NUM_REQ-1:0]   i_Req,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  input  logic [NUM_REQ-1:0]   i_Req_Last,
  output logic [NUM_REQ-1:0]   o_Gnt,
  output logic [NUM_REQ-1:0]   o_Done,
  output logic                 o_Busy,
  output logic                 o_Tx_DV,
  output logic [7:0]           o_Tx_Byte,
  input  logic                 i_Tx_Active,
  input  logic                 i_Tx_Done,
  output logic [2:0]           o_Dbg_State
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_DRAIN     = 3'd0,
    S_IDLE      = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_ACT  = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] ptr_q, owner_q, win, cand;
  logic            win_vld;
  logic            lock_q, lock_expire;
  logic [15:0]     idle_cnt_q;
  logic [1:0]      act_cnt_q;
  int              idx;

  assign o_Dbg_State = state_q;

  // Handshake: a source holds i_Req with its byte/last stable until it sees its
  // o_Gnt pulse; the byte is captured on that cycle and i_Req may then change.
  always_comb begin
    win         = '0;
    win_vld     = 1'b0;
    cand        = '0;
    idx         = 0;
    lock_expire = lock_q && !i_Req[owner_q] &&
                  (idle_cnt_q == 16'(LOCK_TIMEOUT - 1));
    if (lock_q && !lock_expire) begin
      win     = owner_q;
      win_vld = i_Req[owner_q];
    end else begin
      // Scan downward so the lowest offset from ptr_q is the last (winning) write.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        idx = int'(ptr_q) + i;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        cand = idx[IDXW-1:0];
        if (i_Req[cand]) begin
          win     = cand;
          win_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_DRAIN:     if (!i_Tx_Active && !i_Tx_Done) state_d = S_IDLE;
      S_IDLE:      if (win_vld) state_d = S_ISSUE;
      S_ISSUE:     state_d = S_WAIT_ACT;
      S_WAIT_ACT: begin
        if (i_Tx_Active)            state_d = S_WAIT_DONE;
        else if (act_cnt_q == 2'd3) state_d = S_DRAIN;
      end
      S_WAIT_DONE: if (i_Tx_Done) state_d = S_DRAIN;
      default:     state_d = S_DRAIN;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= S_DRAIN;
      ptr_q      <= '0;
      owner_q    <= '0;
      lock_q     <= 1'b0;
      idle_cnt_q <= '0;
      act_cnt_q  <= '0;
      o_Gnt      <= '0;
      o_Done     <= '0;
      o_Busy     <= 1'b0;
      o_Tx_DV    <= 1'b0;
      o_Tx_Byte  <= '0;
    end else begin
      state_q   <= state_d;
      o_Busy    <= (state_d != S_IDLE);
      o_Gnt     <= '0;
      o_Done    <= '0;
      o_Tx_DV   <= 1'b0;
      act_cnt_q <= (state_q == S_WAIT_ACT) ? act_cnt_q + 2'd1 : 2'd0;

      if (state_q == S_IDLE && lock_q) begin
        if (lock_expire) begin
          lock_q     <= 1'b0;
          idle_cnt_q <= '0;
        end else if (!i_Req[owner_q]) begin
          idle_cnt_q <= idle_cnt_q + 16'd1;
        end
      end

      // Issue outputs are registered so they are visible during S_ISSUE.
      if (state_q == S_IDLE && win_vld) begin
        o_Tx_DV      <= 1'b1;
        o_Tx_Byte    <= i_Req_Byte[{win, 3'b000} +: 8];
        o_Gnt[win]   <= 1'b1;
        owner_q      <= win;
        ptr_q        <= (win == LAST_IDX) ? '0 : win + 1'b1;
        lock_q       <= ~i_Req_Last[win];
        idle_cnt_q   <= '0;
      end

      if (state_q == S_WAIT_DONE && i_Tx_Done) o_Done[owner_q] <= 1'b1;
    end
  end

endmodule
